cube_line_sequencer: RTL and testbench

Frame-level controller for the cube wireframe path. On each frame start it optionally requests a framebuffer clear, then walks line_id 0..NUM_LINES-1 through the get_cube endpoint generator. Each line's captured endpoints go to the downstream line rasterizer over a valid/ready handshake, and the block waits for the rasterizer's completion pulse before advancing. It sits between the VGA timing generator (frame_start), get_cube (line_id → x0..y1) and the line drawer / framebuffer clear engine.

---
 rtl/cube_pkg.sv | 24 ++
 rtl/cube_line_sequencer_lat_wait.sv | 27 ++
 rtl/cube_line_sequencer.sv | 127 ++++++++++++
 tb/tb_cube_line_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cube_pkg.sv
// Shared types and default sizes for the cube wireframe path
// (get_cube, cube_line_sequencer, line rasterizer).
package cube_pkg;

   localparam int CUBE_CW        = 16;
   localparam int CUBE_NUM_LINES = 12;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      LOOKUP,
      ISSUE,
      DRAW,
      DONE
   } seq_state_t;

   typedef struct packed {
      logic [CUBE_CW-1:0] x0;
      logic [CUBE_CW-1:0] y0;
      logic [CUBE_CW-1:0] x1;
      logic [CUBE_CW-1:0] y1;
   } line_t;

endpackage

// File: rtl/cube_line_sequencer_lat_wait.sv
// Loadable down-counter; done is high whenever the count has reached zero.
// Loading N gives N+1 cycles before done is seen in the loaded state.
module lat_wait #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - W'(1);
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/cube_line_sequencer.sv
// Frame sequencer: optional framebuffer clear, then walks line_id through
// get_cube and hands each endpoint bundle to the rasterizer.
module cube_line_sequencer
   import cube_pkg::*;
#(
   parameter int NUM_LINES  = CUBE_NUM_LINES,
   parameter int ID_W       = 32,
   parameter int CW         = CUBE_CW,
   parameter int LOOKUP_LAT = 1,
   parameter int CLEAR_EN   = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            frame_start,
   output logic [ID_W-1:0] line_id,
   input  logic [CW-1:0]   x0_in,
   input  logic [CW-1:0]   y0_in,
   input  logic [CW-1:0]   x1_in,
   input  logic [CW-1:0]   y1_in,
   output logic            clear_req,
   input  logic            clear_done,
   output logic            line_valid,
   input  logic            line_ready,
   output logic [CW-1:0]   x0,
   output logic [CW-1:0]   y0,
   output logic [CW-1:0]   x1,
   output logic [CW-1:0]   y1,
   input  logic            draw_done,
   output logic            busy,
   output logic            frame_done,
   output logic            frame_overrun
);

   localparam int              WAIT_W  = (LOOKUP_LAT > 0) ? $clog2(LOOKUP_LAT + 1) : 1;
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_LINES - 1);

   typedef struct packed {
      logic [CW-1:0] x0;
      logic [CW-1:0] y0;
      logic [CW-1:0] x1;
      logic [CW-1:0] y1;
   } ends_t;

   seq_state_t state, state_nx;
   ends_t      ends_q;
   logic       enter_lookup;
   logic       wait_done;
   logic       last_line;
   logic       accept;

   assign last_line = (line_id == LAST_ID);
   assign accept    = line_valid && line_ready;

   // The wait counter is reloaded on every entry into LOOKUP, so its
   // done flag marks the final of LOOKUP_LAT+1 cycles there.
   lat_wait #(.W(WAIT_W)) u_lat_wait (
      .clk      (clk),
      .rst      (rst),
      .load     (enter_lookup),
      .load_val (WAIT_W'(LOOKUP_LAT)),
      .done     (wait_done)
   );

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_nx     = state;
      enter_lookup = 1'b0;
      case (state)
         IDLE:
            if (frame_start) begin
               state_nx     = (CLEAR_EN != 0) ? CLEAR : LOOKUP;
               enter_lookup = (CLEAR_EN == 0);
            end
         CLEAR:
            if (clear_done) begin
               state_nx     = LOOKUP;
               enter_lookup = 1'b1;
            end
         LOOKUP:
            if (wait_done) state_nx = ISSUE;
         ISSUE:
            if (accept) state_nx = DRAW;
         DRAW:
            if (draw_done) begin
               state_nx     = last_line ? DONE : LOOKUP;
               enter_lookup = !last_line;
            end
         DONE:
            state_nx = IDLE;
         default:
            state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         line_id       <= '0;
         ends_q        <= '0;
         line_valid    <= 1'b0;
         clear_req     <= 1'b0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
         frame_overrun <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && frame_start)
            line_id <= '0;
         else if (state == DRAW && draw_done && !last_line)
            line_id <= line_id + ID_W'(1);
         if (state == LOOKUP && wait_done)
            ends_q <= '{x0: x0_in, y0: y0_in, x1: x1_in, y1: y1_in};
         // valid rises one cycle into ISSUE and falls right after the accept
         line_valid    <= (state == ISSUE) && !accept;
         clear_req     <= (state_nx == CLEAR);
         busy          <= (state_nx != IDLE);
         frame_done    <= (state_nx == DONE);
         frame_overrun <= frame_start && (state != IDLE);
      end
   end

   assign x0 = ends_q.x0;
   assign y0 = ends_q.y0;
   assign x1 = ends_q.x1;
   assign y1 = ends_q.y1;

endmodule

// File: tb/tb_cube_line_sequencer.sv
// Scoreboard bench: dut_a (no clear, 1-cycle lookup) and dut_b (clear, 3-cycle
// lookup) driven with random endpoint tables and a get_cube delay model.
module tb_cube_line_sequencer;
   import cube_pkg::*;

   localparam int N     = CUBE_NUM_LINES;
   localparam int LAT_A = 1;
   localparam int LAT_B = 3;

   typedef struct packed {
      logic [31:0] id;
      line_t       ln;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst [2];
   logic        frame_start [2];
   logic        clear_done [2];
   logic        line_ready [2];
   logic        draw_done [2];
   logic [31:0] line_id [2];
   line_t       gc [2];
   logic        clear_req [2];
   logic        line_valid [2];
   logic        busy [2];
   logic        frame_done [2];
   logic        frame_overrun [2];
   logic [CUBE_CW-1:0] x0 [2], y0 [2], x1 [2], y1 [2];

   int total = 0;
   int bad   = 0;
   exp_t q0[$], q1[$];
   int exp_done [2] = '{0, 0};
   int got_done [2] = '{0, 0};
   int exp_ovr  [2] = '{0, 0};
   int got_ovr  [2] = '{0, 0};
   line_t tbl [N];

   cube_line_sequencer #(
      .NUM_LINES(N), .ID_W(32), .CW(CUBE_CW), .LOOKUP_LAT(LAT_A), .CLEAR_EN(0)
   ) dut_a (
      .clk(clk), .rst(rst[0]), .frame_start(frame_start[0]), .line_id(line_id[0]),
      .x0_in(gc[0].x0), .y0_in(gc[0].y0), .x1_in(gc[0].x1), .y1_in(gc[0].y1),
      .clear_req(clear_req[0]), .clear_done(clear_done[0]),
      .line_valid(line_valid[0]), .line_ready(line_ready[0]),
      .x0(x0[0]), .y0(y0[0]), .x1(x1[0]), .y1(y1[0]),
      .draw_done(draw_done[0]), .busy(busy[0]), .frame_done(frame_done[0]),
      .frame_overrun(frame_overrun[0])
   );

   cube_line_sequencer #(
      .NUM_LINES(N), .ID_W(32), .CW(CUBE_CW), .LOOKUP_LAT(LAT_B), .CLEAR_EN(1)
   ) dut_b (
      .clk(clk), .rst(rst[1]), .frame_start(frame_start[1]), .line_id(line_id[1]),
      .x0_in(gc[1].x0), .y0_in(gc[1].y0), .x1_in(gc[1].x1), .y1_in(gc[1].y1),
      .clear_req(clear_req[1]), .clear_done(clear_done[1]),
      .line_valid(line_valid[1]), .line_ready(line_ready[1]),
      .x0(x0[1]), .y0(y0[1]), .x1(x1[1]), .y1(y1[1]),
      .draw_done(draw_done[1]), .busy(busy[1]), .frame_done(frame_done[1]),
      .frame_overrun(frame_overrun[1])
   );

   // get_cube model: endpoints for an id appear LAT cycles after the id does
   function automatic line_t lookup(input logic [31:0] id);
      if (id < N) return tbl[int'(id)];
      return line_t'(64'hDEAD_BEEF_0BAD_F00D);
   endfunction

   logic [31:0] pb1, pb2;
   always @(posedge clk) begin
      gc[0] <= lookup(line_id[0]);
      pb1   <= line_id[1];
      pb2   <= pb1;
      gc[1] <= lookup(pb2);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void push_exp(input int i, input exp_t e);
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
   endfunction

   function automatic int q_size(input int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   function automatic exp_t pop_exp(input int i);
      return (i == 0) ? q0.pop_front() : q1.pop_front();
   endfunction

   // monitor: every accepted bundle must be the next expected line
   task automatic mon(input int i);
      exp_t e;
      if (rst[i] === 1'b1) return;
      if (frame_overrun[i] === 1'b1) got_ovr[i]++;
      if (frame_done[i] === 1'b1) got_done[i]++;
      if (line_valid[i] === 1'b1 && line_ready[i] === 1'b1) begin
         if (q_size(i) == 0) begin
            check($sformatf("unexpected_accept[%0d]", i), 64'(q_size(i)), 64'd1);
         end else begin
            e = pop_exp(i);
            check($sformatf("accept_id[%0d]", i), 64'(line_id[i]), 64'(e.id));
            check($sformatf("accept_ends[%0d]_id%0d", i, e.id),
                  {x0[i], y0[i], x1[i], y1[i]}, e.ln);
         end
      end
   endtask

   always @(negedge clk) mon(0);
   always @(negedge clk) mon(1);

   task automatic run_frame(input int i, input int bp_line, input int ovr_line,
                            input int coinc_line, input int rst_line, input int clr_wait);
      int          e0;
      int          waited;
      int          lat;
      bit          err;
      logic [63:0] snap;
      lat = (i == 0) ? LAT_A : LAT_B;
      for (int k = 0; k < N; k++) begin
         tbl[k] = line_t'({$urandom, $urandom});
         if (rst_line < 0 || k <= rst_line) push_exp(i, '{id: 32'(k), ln: tbl[k]});
      end
      line_ready[i]  = (bp_line != 0 && ovr_line != 0);
      frame_start[i] = 1'b1;
      e0 = cyc + 1;
      tick();
      frame_start[i] = 1'b0;

      if (clr_wait > 0) begin
         err = 1'b0;
         for (int w = 0; w < clr_wait; w++) begin
            err |= (clear_req[i] !== 1'b1) || (line_valid[i] !== 1'b0);
            frame_start[i] = (w == 3);
            if (w == 3) exp_ovr[i]++;
            tick();
         end
         frame_start[i] = 1'b0;
         clear_done[i]  = 1'b1;
         check("clear_req_held_no_valid", 64'(err), 64'd0);
         check("clear_req_on_done_cycle", 64'(clear_req[i]), 64'd1);
         e0 = cyc + 1;
         tick();
         clear_done[i] = 1'b0;
         check("clear_req_drop", 64'(clear_req[i]), 64'd0);
      end

      for (int k = 0; k < N; k++) begin
         line_ready[i] = (k != bp_line && k != ovr_line);
         waited = 0;
         while (line_valid[i] !== 1'b1 && waited < 40) begin
            tick();
            waited++;
         end
         if (line_valid[i] !== 1'b1) begin
            check($sformatf("line_valid_timeout[%0d]_line%0d", i, k), 64'(line_valid[i]), 64'd1);
            line_ready[i] = 1'b1;
            return;
         end
         if (k == 0) check($sformatf("first_valid_latency[%0d]", i), 64'(cyc - e0), 64'(lat + 2));

         if (k == bp_line) begin
            snap = {x0[i], y0[i], x1[i], y1[i]};
            err  = 1'b0;
            for (int c = 0; c < 5; c++) begin
               err |= (line_valid[i] !== 1'b1) || ({x0[i], y0[i], x1[i], y1[i]} !== snap);
               tick();
            end
            check("backpressure_hold", 64'(err), 64'd0);
            line_ready[i] = 1'b1;
         end

         if (k == ovr_line) begin
            frame_start[i] = 1'b1;
            draw_done[i]   = 1'b1;
            exp_ovr[i]++;
            tick();
            frame_start[i] = 1'b0;
            draw_done[i]   = 1'b0;
            check("stray_draw_done_ignored", 64'(line_valid[i]), 64'd1);
            line_ready[i] = 1'b1;
         end

         draw_done[i] = (k == coinc_line);
         tick();
         draw_done[i] = 1'b0;
         check($sformatf("valid_drop[%0d]_line%0d", i, k), 64'(line_valid[i]), 64'd0);

         if (k == rst_line) begin
            tick();
            rst[i] = 1'b1;
            tick();
            rst[i] = 1'b0;
            check("mid_reset_ctrl",
                  64'({busy[i], line_valid[i], clear_req[i], frame_done[i], line_id[i]}), 64'd0);
            check("mid_reset_ends", {x0[i], y0[i], x1[i], y1[i]}, 64'd0);
            return;
         end

         tick();
         tick();
         draw_done[i] = 1'b1;
         tick();
         draw_done[i] = 1'b0;
         if (k == N - 1) begin
            exp_done[i]++;
            check($sformatf("frame_done_pulse[%0d]", i), 64'({frame_done[i], busy[i]}), 64'b11);
            tick();
            check($sformatf("frame_end_idle[%0d]", i), 64'({frame_done[i], busy[i]}), 64'b00);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst[i]         = 1'b1;
         frame_start[i] = 1'b0;
         clear_done[i]  = 1'b0;
         draw_done[i]   = 1'b0;
         line_ready[i]  = 1'b1;
      end
      for (int k = 0; k < N; k++) tbl[k] = line_t'({$urandom, $urandom});
      repeat (3) tick();
      for (int i = 0; i < 2; i++) begin
         check($sformatf("reset_ctrl[%0d]", i),
               64'({busy[i], line_valid[i], clear_req[i], frame_done[i], frame_overrun[i], line_id[i]}),
               64'd0);
         check($sformatf("reset_ends[%0d]", i), {x0[i], y0[i], x1[i], y1[i]}, 64'd0);
         rst[i] = 1'b0;
      end
      tick();

      run_frame(0, -1, -1, -1, -1, 0);
      repeat (3) tick();
      run_frame(0, 4, -1, -1, -1, 0);
      repeat (3) tick();
      run_frame(0, -1, 6, 2, -1, 0);
      repeat (3) tick();
      run_frame(0, -1, -1, -1, 7, 0);
      repeat (4) tick();
      run_frame(0, -1, -1, -1, -1, 0);
      repeat (3) tick();
      run_frame(1, -1, -1, -1, -1, 20);
      repeat (3) tick();
      run_frame(1, 0, -1, 5, -1, int'($urandom_range(4, 9)));
      repeat (5) tick();

      for (int i = 0; i < 2; i++) begin
         check($sformatf("leftover_expected[%0d]", i), 64'(q_size(i)), 64'd0);
         check($sformatf("frame_done_count[%0d]", i), 64'(got_done[i]), 64'(exp_done[i]));
         check($sformatf("overrun_count[%0d]", i), 64'(got_ovr[i]), 64'(exp_ovr[i]));
         check($sformatf("final_idle[%0d]", i), 64'(busy[i]), 64'd0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
